// File: rtl/wb_commit_ctrl.sv
// Writeback-stage commit controller: exception prioritisation, CSR requests, RF commit, flush.
// Optional WB_EXC_CNT_EN adds a free-running exception counter output exc_cnt.
module wb_commit_ctrl #(
    parameter int unsigned RF_AW  = 5,
    parameter int unsigned CSR_NW = 14
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef WB_EXC_CNT_EN
    output logic [31:0]       exc_cnt,
`endif
    input  logic              ms_valid,
    output logic              ws_allowin,
    input  logic [31:0]       ms_pc,
    input  logic [4:0]        ms_exc,
    input  logic [31:0]       ms_vaddr,
    input  logic              ms_is_ertn,
    input  logic [1:0]        ms_csr_op,
    input  logic [CSR_NW-1:0] ms_csr_num,
    input  logic [31:0]       ms_rj_value,
    input  logic [31:0]       ms_rkd_value,
    input  logic              ms_rf_we,
    input  logic [RF_AW-1:0]  ms_rf_waddr,
    input  logic [31:0]       ms_result,
    input  logic              has_int,
    input  logic [31:0]       csr_rd_value,
    input  logic [31:0]       csr_eentry_pc,
    input  logic [31:0]       csr_eertn_pc,
    output logic [5:0]        exc,
    output logic              ertn_flush,
    output logic              csr_re,
    output logic [CSR_NW-1:0] csr_rd_num,
    output logic              csr_we,
    output logic [CSR_NW-1:0] csr_wr_num,
    output logic [31:0]       csr_wr_mask,
    output logic [31:0]       csr_wr_value,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_fault_vaddr,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              flush,
    output logic [31:0]       flush_pc,
    input  logic              flush_ack
);

    typedef enum logic [0:0] {StRun, StFlushWait} state_e;

    state_e             state_q;
    logic               ws_valid_q;
    logic [31:0]        pc_q;
    logic [4:0]         exc_q;
    logic [31:0]        vaddr_q;
    logic               ertn_q;
    logic [1:0]         csr_op_q;
    logic [CSR_NW-1:0]  csr_num_q;
    logic [31:0]        rj_q;
    logic [31:0]        rkd_q;
    logic               rf_we_q;
    logic [RF_AW-1:0]   rf_waddr_q;
    logic [31:0]        result_q;
    logic [31:0]        flush_pc_q;

    logic               run;
    logic               active;
    logic               int_t;
    logic               ex_any;
    logic               commit_flush;
    logic [31:0]        redirect_pc;

    assign run        = (state_q == StRun);
    assign active     = ws_valid_q & run;
    assign int_t      = has_int & active;
    assign ws_allowin = 1'b1;

    // ms_exc bit positions already match exc[4:0]; only the priority order differs.
    always_comb begin
        exc = 6'b0;
        if (active) begin
            if (int_t)         exc[5] = 1'b1;
            else if (exc_q[4]) exc[4] = 1'b1;
            else if (exc_q[1]) exc[1] = 1'b1;
            else if (exc_q[0]) exc[0] = 1'b1;
            else if (exc_q[2]) exc[2] = 1'b1;
            else if (exc_q[3]) exc[3] = 1'b1;
        end
    end

    assign ex_any       = |exc;
    assign ertn_flush   = active & ertn_q & ~ex_any;
    assign commit_flush = ex_any | ertn_flush;
    assign redirect_pc  = ex_any ? csr_eentry_pc : csr_eertn_pc;

    assign flush    = commit_flush | (state_q == StFlushWait);
    assign flush_pc = commit_flush ? redirect_pc : flush_pc_q;

    assign csr_re       = active & (csr_op_q != 2'b00);
    assign csr_rd_num   = csr_num_q;
    assign csr_wr_num   = csr_num_q;
    assign csr_we       = active & csr_op_q[1] & ~ex_any;
    assign csr_wr_value = rkd_q;

    always_comb begin
        csr_wr_mask = 32'h0;
        if (csr_op_q == 2'b10)      csr_wr_mask = 32'hFFFF_FFFF;
        else if (csr_op_q == 2'b11) csr_wr_mask = rj_q;
    end

    // CSR ops write back the pre-write CSR value read combinationally this cycle.
    assign rf_we          = active & rf_we_q & ~ex_any;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = (csr_op_q != 2'b00) ? csr_rd_value : result_q;
    assign wb_pc          = pc_q;
    assign wb_fault_vaddr = vaddr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StRun;
            ws_valid_q <= 1'b0;
            pc_q       <= '0;
            exc_q      <= '0;
            vaddr_q    <= '0;
            ertn_q     <= 1'b0;
            csr_op_q   <= '0;
            csr_num_q  <= '0;
            rj_q       <= '0;
            rkd_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
            flush_pc_q <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    ws_valid_q <= ms_valid & ws_allowin;
                    if (ms_valid & ws_allowin) begin
                        pc_q       <= ms_pc;
                        exc_q      <= ms_exc;
                        vaddr_q    <= ms_vaddr;
                        ertn_q     <= ms_is_ertn;
                        csr_op_q   <= ms_csr_op;
                        csr_num_q  <= ms_csr_num;
                        rj_q       <= ms_rj_value;
                        rkd_q      <= ms_rkd_value;
                        rf_we_q    <= ms_rf_we;
                        rf_waddr_q <= ms_rf_waddr;
                        result_q   <= ms_result;
                    end
                    if (commit_flush) begin
                        flush_pc_q <= redirect_pc;
                        if (!flush_ack) state_q <= StFlushWait;
                    end
                end
                StFlushWait: begin
                    ws_valid_q <= 1'b0;
                    if (flush_ack) state_q <= StRun;
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef WB_EXC_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     exc_cnt <= '0;
        else if (ex_any) exc_cnt <= exc_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Scoreboard bench for wb_commit_ctrl: driver pushes per-cycle expectations, monitor compares.
module tb_wb_commit_ctrl;

    localparam int RF_AW  = 5;
    localparam int CSR_NW = 14;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic              ms_valid, ms_is_ertn, ms_rf_we, has_int, flush_ack;
    logic [31:0]       ms_pc, ms_vaddr, ms_rj_value, ms_rkd_value, ms_result;
    logic [31:0]       csr_rd_value, csr_eentry_pc, csr_eertn_pc;
    logic [4:0]        ms_exc;
    logic [1:0]        ms_csr_op;
    logic [CSR_NW-1:0] ms_csr_num;
    logic [RF_AW-1:0]  ms_rf_waddr;

    logic              ws_allowin, ertn_flush, csr_re, csr_we, rf_we, flush;
    logic [5:0]        exc;
    logic [CSR_NW-1:0] csr_rd_num, csr_wr_num;
    logic [31:0]       csr_wr_mask, csr_wr_value, wb_pc, wb_fault_vaddr, rf_wdata, flush_pc;
    logic [RF_AW-1:0]  rf_waddr;
`ifdef WB_EXC_CNT_EN
    logic [31:0]       exc_cnt;
`endif

    wb_commit_ctrl #(.RF_AW(RF_AW), .CSR_NW(CSR_NW)) dut (
        .clk(clk), .resetn(resetn),
`ifdef WB_EXC_CNT_EN
        .exc_cnt(exc_cnt),
`endif
        .ms_valid(ms_valid), .ws_allowin(ws_allowin), .ms_pc(ms_pc), .ms_exc(ms_exc),
        .ms_vaddr(ms_vaddr), .ms_is_ertn(ms_is_ertn), .ms_csr_op(ms_csr_op),
        .ms_csr_num(ms_csr_num), .ms_rj_value(ms_rj_value), .ms_rkd_value(ms_rkd_value),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_result(ms_result),
        .has_int(has_int), .csr_rd_value(csr_rd_value), .csr_eentry_pc(csr_eentry_pc),
        .csr_eertn_pc(csr_eertn_pc), .exc(exc), .ertn_flush(ertn_flush), .csr_re(csr_re),
        .csr_rd_num(csr_rd_num), .csr_we(csr_we), .csr_wr_num(csr_wr_num),
        .csr_wr_mask(csr_wr_mask), .csr_wr_value(csr_wr_value), .wb_pc(wb_pc),
        .wb_fault_vaddr(wb_fault_vaddr), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flush(flush), .flush_pc(flush_pc), .flush_ack(flush_ack)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic [31:0] vaddr;
        logic        ertn;
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] rj, rkd;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic        has_int;
        logic [31:0] rd_value, eentry, eertn;
        logic        ack;
    } stim_t;

    typedef struct {
        logic [5:0]  exc;
        logic        ertn, re, we, rf_we, flush;
        logic [13:0] num;
        logic [31:0] mask, value, wdata, pc, vaddr, fpc, cnt;
        logic [4:0]  waddr;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: the instruction sitting in WB, whether we await an ack, held redirect.
    stim_t       m_b;
    logic        m_valid, m_wait;
    logic [31:0] m_fpc, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rd_value = $urandom;
        s.eentry   = $urandom;
        s.eertn    = $urandom;
        s.ack      = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = idle();
        s.valid   = ($urandom_range(3) != 0);
        s.pc      = $urandom;
        s.exc     = ($urandom_range(3) == 0) ? 5'($urandom) : 5'b0;
        s.vaddr   = $urandom;
        s.ertn    = ($urandom_range(15) == 0);
        s.op      = 2'($urandom);
        s.num     = 14'($urandom);
        s.rj      = $urandom;
        s.rkd     = $urandom;
        s.rf_we   = 1'($urandom);
        s.waddr   = 5'($urandom);
        s.result  = $urandom;
        s.has_int = ($urandom_range(7) == 0);
        s.ack     = 1'($urandom);
        return s;
    endfunction

    task automatic model_reset();
        m_b     = '{default: '0};
        m_valid = 1'b0;
        m_wait  = 1'b0;
        m_fpc   = '0;
        m_cnt   = '0;
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        logic [5:0] cause;
        int prio[6] = '{5, 4, 1, 0, 2, 3};
        logic act, ev;
        @(posedge clk);
        #1;
        ms_valid = s.valid; ms_pc = s.pc; ms_exc = s.exc; ms_vaddr = s.vaddr;
        ms_is_ertn = s.ertn; ms_csr_op = s.op; ms_csr_num = s.num; ms_rj_value = s.rj;
        ms_rkd_value = s.rkd; ms_rf_we = s.rf_we; ms_rf_waddr = s.waddr; ms_result = s.result;
        has_int = s.has_int; csr_rd_value = s.rd_value; csr_eentry_pc = s.eentry;
        csr_eertn_pc = s.eertn; flush_ack = s.ack;

        act   = m_valid && !m_wait;
        cause = {s.has_int, m_b.exc};
        e.exc = 6'b0;
        if (act) begin
            for (int i = 0; i < 6; i++) begin
                if (cause[prio[i]]) begin
                    e.exc[prio[i]] = 1'b1;
                    break;
                end
            end
        end
        e.ertn  = act && m_b.ertn && (e.exc == 0);
        ev      = (e.exc != 0) || e.ertn;
        e.flush = ev || m_wait;
        e.fpc   = ev ? ((e.exc != 0) ? s.eentry : s.eertn) : m_fpc;
        e.re    = act && (m_b.op != 2'b00);
        e.we    = act && m_b.op[1] && (e.exc == 0);
        e.num   = m_b.num;
        e.mask  = (m_b.op == 2'b10) ? 32'hFFFF_FFFF : (m_b.op == 2'b11) ? m_b.rj : 32'h0;
        e.value = m_b.rkd;
        e.rf_we = act && m_b.rf_we && (e.exc == 0);
        e.waddr = m_b.waddr;
        e.wdata = (m_b.op != 2'b00) ? s.rd_value : m_b.result;
        e.pc    = m_b.pc;
        e.vaddr = m_b.vaddr;
        if (e.exc != 0) m_cnt = m_cnt + 1;
        e.cnt   = m_cnt - ((e.exc != 0) ? 32'd1 : 32'd0);
        q.push_back(e);

        if (!m_wait) begin
            m_valid = s.valid;
            if (s.valid) m_b = s;
            if (ev) begin
                m_fpc = e.fpc;
                if (!s.ack) m_wait = 1'b1;
            end
        end else begin
            m_valid = 1'b0;
            if (s.ack) m_wait = 1'b0;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!resetn) begin
            q.delete();
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("allowin", 32'(ws_allowin), 32'd1);
            chk("exc", 32'(exc), 32'(e.exc));
            chk("ertn_flush", 32'(ertn_flush), 32'(e.ertn));
            chk("flush", 32'(flush), 32'(e.flush));
            chk("flush_pc", flush_pc, e.fpc);
            chk("csr_re", 32'(csr_re), 32'(e.re));
            chk("csr_we", 32'(csr_we), 32'(e.we));
            chk("csr_rd_num", 32'(csr_rd_num), 32'(e.num));
            chk("csr_wr_num", 32'(csr_wr_num), 32'(e.num));
            chk("csr_wr_mask", csr_wr_mask, e.mask);
            chk("csr_wr_value", csr_wr_value, e.value);
            chk("rf_we", 32'(rf_we), 32'(e.rf_we));
            chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
            chk("rf_wdata", rf_wdata, e.wdata);
            chk("wb_pc", wb_pc, e.pc);
            chk("wb_fault_vaddr", wb_fault_vaddr, e.vaddr);
`ifdef WB_EXC_CNT_EN
            chk("exc_cnt", exc_cnt, e.cnt);
`endif
        end
    end

    task automatic reset_checks();
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_allowin", 32'(ws_allowin), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_csr_we", 32'(csr_we), 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
`ifdef WB_EXC_CNT_EN
        chk("rst_exc_cnt", exc_cnt, 32'd0);
`endif
    endtask

    initial begin
        stim_t s;
        ms_valid = 0; ms_pc = 0; ms_exc = 0; ms_vaddr = 0; ms_is_ertn = 0; ms_csr_op = 0;
        ms_csr_num = 0; ms_rj_value = 0; ms_rkd_value = 0; ms_rf_we = 0; ms_rf_waddr = 0;
        ms_result = 0; has_int = 0; csr_rd_value = 0; csr_eentry_pc = 0; csr_eertn_pc = 0;
        flush_ack = 0;
        model_reset();
        #3;
        reset_checks();
        #9 resetn = 1'b1;

        s = idle(); apply(s);
        // csrwr, then csrxchg, then a bubble so the second one reaches WB
        s = idle(); s.valid = 1; s.op = 2'b10; s.num = 14'h30; s.rkd = 32'h12345678;
        s.rf_we = 1; s.waddr = 5'd7; s.pc = 32'h1C000000; s.rj = $urandom; apply(s);
        s = idle(); s.valid = 1; s.op = 2'b11; s.num = 14'h31; s.rj = 32'h0000FF00;
        s.rkd = 32'hAAAAAAAA; s.rf_we = 1; s.waddr = 5'd8; s.pc = 32'h1C000004; apply(s);
        s = idle(); apply(s);
        // SYS with three un-acked cycles and two bundles arriving during the wait
        s = idle(); s.valid = 1; s.exc = 5'b00001; s.rf_we = 1; s.pc = 32'h1C000008; apply(s);
        s = idle(); s.eentry = 32'h1C008000; s.ack = 0; apply(s);
        s = idle(); s.ack = 0; s.valid = 1; s.pc = 32'h1C00000C; s.rf_we = 1; apply(s);
        s = idle(); s.ack = 0; s.valid = 1; s.pc = 32'h1C000010; s.rf_we = 1; apply(s);
        s = idle(); s.ack = 1; apply(s);
        s = idle(); apply(s);
        // ADEF+ALE with and without a pending interrupt
        s = idle(); s.valid = 1; s.exc = 5'b11000; apply(s);
        s = idle(); s.has_int = 1; apply(s);
        s = idle(); s.valid = 1; s.exc = 5'b11000; apply(s);
        s = idle(); apply(s);
        // ertn acked in the same cycle, next bundle accepted alongside
        s = idle(); s.valid = 1; s.ertn = 1; s.pc = 32'h1C000020; apply(s);
        s = idle(); s.eertn = 32'h1C000100; s.valid = 1; s.pc = 32'h1C000100; s.rf_we = 1;
        s.waddr = 5'd3; s.result = 32'hCAFE0001; apply(s);
        s = idle(); apply(s);

        for (int i = 0; i < 3000; i++) apply(rnd());

        // reset asserted while waiting for an ack
        s = idle(); s.valid = 1; s.exc = 5'b00100; apply(s);
        s = idle(); s.ack = 0; apply(s);
        s = idle(); s.ack = 0; apply(s);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1 reset_checks();
        model_reset();
        #10 resetn = 1'b1;
        for (int i = 0; i < 50; i++) apply(rnd());

        repeat (2) @(negedge clk);
        #1 chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
